// File: rtl/video_timing.sv
// Raster timing generator: free-running h/v counters with a registered decode of
// pixel/line/frame strobes, active window, field flag and sync pins.
module video_timing #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FRONT  = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BACK   = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FRONT  = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BACK   = 33,
  parameter logic        SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        interlace,
  output logic [9:0]  h_count,
  output logic [9:0]  v_count,
  output logic        display_next_pixel,
  output logic        display_next_line,
  output logic        display_next_frame,
  output logic        display_current_field,
  output logic        active,
  output logic        hsync,
  output logic        vsync
);

  localparam int unsigned CW = 10;
  localparam int unsigned HT = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned VT = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CW-1:0] H_LAST   = CW'(HT - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(VT - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FRONT);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FRONT);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FRONT + V_SYNC);

  logic [CW-1:0] h_next_c;
  logic [CW-1:0] v_next_c;
  logic          h_last_c;
  logic          v_last_c;
  logic          active_c;
  logic          frame_c;
  logic          hsync_c;
  logic          vsync_c;

  // Next counter values and decode of the current (pre-edge) position.
  always_comb begin
    h_last_c = (h_count == H_LAST);
    v_last_c = (v_count == V_LAST);
    h_next_c = h_last_c ? '0 : h_count + CW'(1);
    v_next_c = v_count;
    if (h_last_c) begin
      v_next_c = v_last_c ? '0 : v_count + CW'(1);
    end
    active_c = (h_count < H_ACT) && (v_count < V_ACT);
    frame_c  = h_last_c && v_last_c;
    hsync_c  = ((h_count >= HS_START) && (h_count < HS_END)) ? SYNC_POL : ~SYNC_POL;
    vsync_c  = ((v_count >= VS_START) && (v_count < VS_END)) ? SYNC_POL : ~SYNC_POL;
  end

  // Disable reloads the reset image, so a dropped frame never emits line/frame strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_count               <= '0;
      v_count               <= '0;
      display_next_pixel    <= 1'b0;
      display_next_line     <= 1'b0;
      display_next_frame    <= 1'b0;
      display_current_field <= 1'b0;
      active                <= 1'b0;
      hsync                 <= ~SYNC_POL;
      vsync                 <= ~SYNC_POL;
    end else if (!enable) begin
      h_count               <= '0;
      v_count               <= '0;
      display_next_pixel    <= 1'b0;
      display_next_line     <= 1'b0;
      display_next_frame    <= 1'b0;
      display_current_field <= 1'b0;
      active                <= 1'b0;
      hsync                 <= ~SYNC_POL;
      vsync                 <= ~SYNC_POL;
    end else begin
      h_count            <= h_next_c;
      v_count            <= v_next_c;
      display_next_pixel <= active_c;
      display_next_line  <= h_last_c;
      display_next_frame <= frame_c;
      active             <= active_c;
      hsync              <= hsync_c;
      vsync              <= vsync_c;
      // Interlace is only sampled at the frame boundary.
      if (frame_c) begin
        display_current_field <= interlace & ~display_current_field;
      end
    end
  end

endmodule

// File: tb/tb_video_timing.sv
// Bench for video_timing on a reduced raster (30x15) so whole frames stay short.
module tb_video_timing;

  localparam int HA = 16, HF = 4, HS = 6, HB = 4;
  localparam int VA = 8,  VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       interlace = 1'b0;
  logic [9:0] h_count, v_count;
  logic       display_next_pixel, display_next_line, display_next_frame;
  logic       display_current_field, active, hsync, vsync;

  always #5 clk = ~clk;

  video_timing #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_POL(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .interlace(interlace),
    .h_count(h_count), .v_count(v_count),
    .display_next_pixel(display_next_pixel),
    .display_next_line(display_next_line),
    .display_next_frame(display_next_frame),
    .display_current_field(display_current_field),
    .active(active), .hsync(hsync), .vsync(vsync)
  );

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic pix, line, frame, fld, act, hs, vs;
  } exp_t;

  typedef struct {
    logic en;
    logic il;
    int   n;
  } seg_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   mh = 0, mv = 0;
  logic mfield = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (model h=%0d v=%0d)", name, got, exp, mh, mv);
    end
  endtask

  function automatic exp_t reset_exp();
    exp_t e;
    e = '0;
    e.hs = 1'b1;
    e.vs = 1'b1;
    return e;
  endfunction

  function automatic exp_t sample();
    exp_t s;
    s.h = h_count; s.v = v_count;
    s.pix = display_next_pixel; s.line = display_next_line;
    s.frame = display_next_frame; s.fld = display_current_field;
    s.act = active; s.hs = hsync; s.vs = vsync;
    return s;
  endfunction

  function automatic void model_reset();
    mh = 0; mv = 0; mfield = 1'b0;
  endfunction

  // Reference raster: outputs after an edge describe the position before it.
  function automatic exp_t model_step(input logic en, input logic il);
    exp_t e;
    e = reset_exp();
    if (!en) begin
      model_reset();
    end else begin
      e.act   = (mh < HA) && (mv < VA);
      e.pix   = e.act;
      e.line  = (mh == HT - 1);
      e.frame = e.line && (mv == VT - 1);
      e.hs    = !((mh >= HA + HF) && (mh < HA + HF + HS));
      e.vs    = !((mv >= VA + VF) && (mv < VA + VF + VS));
      if (e.frame) mfield = il ? ~mfield : 1'b0;
      e.fld = mfield;
      if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh = mh + 1;
      end
      e.h = 10'(mh);
      e.v = 10'(mv);
    end
    return e;
  endfunction

  // Drive at negedge, push expectation, compare one step after the posedge.
  task automatic step(input logic en, input logic il, output exp_t got);
    exp_t e;
    enable = en;
    interlace = il;
    q.push_back(model_step(en, il));
    @(posedge clk);
    #1;
    got = sample();
    if (q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = q.pop_front();
      check("cycle", 32'(got), 32'(e));
    end
    @(negedge clk);
  endtask

  initial begin
    seg_t segs[6];
    exp_t g;
    int   run, runs_ok, runs_bad, hs_low, hs_first, vs_low, vs_first;
    int   lines_act, had_pix, frame_no_line, stray, guard;
    int   ev[$];
    logic fv[$];

    segs[0] = '{en: 1'b1, il: 1'b0, n: HT + 7};
    segs[1] = '{en: 1'b0, il: 1'b0, n: 3};
    segs[2] = '{en: 1'b1, il: 1'b1, n: 2 * FT + 11};
    segs[3] = '{en: 1'b1, il: 1'b0, n: FT};
    segs[4] = '{en: 1'b0, il: 1'b1, n: 2};
    segs[5] = '{en: 1'b1, il: 1'b1, n: 40};

    // Reset held with enable high: outputs stay at reset values across edges.
    #2 rst = 1'b0;
    enable = 1'b1;
    #1 check("reset_async", 32'(sample()), 32'(reset_exp()));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 check("reset_hold", 32'(sample()), 32'(reset_exp()));
    end
    @(negedge clk);
    rst = 1'b1;
    model_reset();

    step(1'b1, 1'b0, g);
    check("first_pixel", {g.act, g.pix, g.h}, {1'b1, 1'b1, 10'd1});

    for (int s = 0; s < 6; s++)
      for (int i = 0; i < segs[s].n; i++) step(segs[s].en, segs[s].il, g);

    // Line timing from a fresh start.
    step(1'b0, 1'b0, g);
    run = 0; runs_ok = 0; runs_bad = 0; hs_low = 0; hs_first = -1;
    ev.delete();
    for (int k = 1; k <= 2 * HT; k++) begin
      step(1'b1, 1'b0, g);
      if (g.pix) run++;
      else begin
        if (run == HA) runs_ok++;
        else if (run > 0) runs_bad++;
        run = 0;
      end
      if (g.line) ev.push_back(k);
      if (!g.hs) begin
        hs_low++;
        if (hs_first < 0) hs_first = k;
      end
    end
    check("pix_runs", 32'(runs_ok), 32'd2);
    check("pix_bad_runs", 32'(runs_bad), 32'd0);
    check("line_pulses", 32'(ev.size()), 32'd2);
    check("line_edge0", 32'(ev.size() > 0 ? ev[0] : -1), 32'(HT));
    check("line_edge1", 32'(ev.size() > 1 ? ev[1] : -1), 32'(2 * HT));
    check("hsync_low", 32'(hs_low), 32'(2 * HS));
    check("hsync_first", 32'(hs_first), 32'(HA + HF + 1));

    // Frame timing over two frames.
    step(1'b0, 1'b0, g);
    ev.delete();
    vs_low = 0; vs_first = -1; lines_act = 0; had_pix = 0; frame_no_line = 0;
    for (int k = 1; k <= 2 * FT; k++) begin
      step(1'b1, 1'b0, g);
      if (g.frame) ev.push_back(k);
      if (g.frame && !g.line) frame_no_line++;
      if (!g.vs) begin
        vs_low++;
        if (vs_first < 0) vs_first = k;
      end
      if (g.pix) had_pix = 1;
      if (g.line) begin
        lines_act += had_pix;
        had_pix = 0;
      end
    end
    check("frame_pulses", 32'(ev.size()), 32'd2);
    check("frame_edge0", 32'(ev.size() > 0 ? ev[0] : -1), 32'(FT));
    check("frame_edge1", 32'(ev.size() > 1 ? ev[1] : -1), 32'(2 * FT));
    check("frame_without_line", 32'(frame_no_line), 32'd0);
    check("vsync_low", 32'(vs_low), 32'(2 * VS * HT));
    check("vsync_first", 32'(vs_first), 32'((VA + VF) * HT + 1));
    check("active_lines", 32'(lines_act), 32'(2 * VA));

    // Interlace: field toggles per frame, interlace change waits for the boundary.
    step(1'b0, 1'b1, g);
    check("field_start", 32'(g.fld), 32'd0);
    fv.delete();
    for (int k = 1; k <= 3 * FT; k++) begin
      step(1'b1, 1'b1, g);
      if (g.frame) fv.push_back(g.fld);
    end
    check("field_count", 32'(fv.size()), 32'd3);
    check("field_seq", {29'd0, fv.size() > 0 ? fv[0] : 1'bx, fv.size() > 1 ? fv[1] : 1'bx,
                        fv.size() > 2 ? fv[2] : 1'bx}, 32'b101);
    for (int k = 1; k <= FT / 2; k++) step(1'b1, 1'b0, g);
    check("field_hold_midframe", 32'(g.fld), 32'd1);
    for (int k = FT / 2 + 1; k <= FT; k++) step(1'b1, 1'b0, g);
    check("field_cleared_at_frame", {g.frame, g.fld}, {1'b1, 1'b0});

    // Mid-frame disable.
    guard = 0;
    while (!(mh == 10 && mv == 5) && guard < 2 * FT) begin
      step(1'b1, 1'b0, g);
      guard++;
    end
    check("reach_disable_point", 32'(guard < 2 * FT), 32'd1);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, g);
    check("disabled_state", 32'(g), 32'(reset_exp()));
    step(1'b1, 1'b0, g);
    check("reenable_pixel", {g.pix, g.frame}, {1'b1, 1'b0});
    stray = 0;
    for (int k = 2; k < FT; k++) begin
      step(1'b1, 1'b0, g);
      stray += int'(g.frame);
    end
    check("no_stray_frame", 32'(stray), 32'd0);
    step(1'b1, 1'b0, g);
    check("frame_after_reenable", 32'(g.frame), 32'd1);

    // Async reset while both syncs are asserted.
    guard = 0;
    while (!(mh == HA + HF + 2 && mv == VA + VF) && guard < 2 * FT) begin
      step(1'b1, 1'b0, g);
      guard++;
    end
    check("reach_sync_point", 32'(guard < 2 * FT), 32'd1);
    check("syncs_asserted", {g.hs, g.vs}, 2'b00);
    #2 rst = 1'b0;
    #1 check("async_reset", 32'(sample()), 32'(reset_exp()));
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 1'b0, g);
    check("after_async_reset", {g.pix, g.h}, {1'b1, 10'd1});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/video_timing.md
Name: video_timing

Overview:
- Generates the raster timing that drives the display path: pixel/line/frame strobes and the field flag consumed by the composer.
- Also drives the hsync/vsync pins for the VGA output.
- Sits directly upstream of the composer's display interface; one instance, clocked at the 25 MHz pixel clock (one pixel per clock).
- Default parameters give 640x480@60 (800x525 total).

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync width (clocks)
- H_BACK, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_POL, 0, sync pin polarity when asserted (0 = active-low)

Ports:
- clk  input  1  pixel clock
- rst  input  1  asynchronous, active-low reset
- enable  input  1  timing runs when 1; driven from display_mode != 0
- interlace  input  1  1 = toggle field every frame
- h_count  output  10  horizontal counter register, 0..HT-1 (HT = sum of H_*)
- v_count  output  10  vertical counter register, 0..VT-1 (VT = sum of V_*)
- display_next_pixel  output  1  one pulse per active pixel
- display_next_line  output  1  one-cycle pulse at end of each line
- display_next_frame  output  1  one-cycle pulse at end of each frame
- display_current_field  output  1  current field, 0/1
- active  output  1  inside active window
- hsync  output  1  horizontal sync pin
- vsync  output  1  vertical sync pin

Behaviour:
- Reset (rst=0, asynchronous):
  - h_count = 0, v_count = 0.
  - All strobes and active = 0; display_current_field = 0.
  - hsync and vsync = ~SYNC_POL (deasserted).
- Disabled (enable=0 at an edge): same values are loaded synchronously.
  - Counters hold at 0 while disabled.
  - Dropping enable mid-frame aborts the frame. No next_line or next_frame pulse is emitted for it.
- Counters, when enable=1:
  - h_count increments each clock and wraps HT-1 -> 0.
  - On that wrap, v_count increments and wraps VT-1 -> 0.
  - Widths fixed at 10 bits. HT and VT must be <= 1024; this is a parameter constraint, not checked at runtime.
- Decode (registered): every other output is a one-cycle-delayed decode of the (h_count, v_count) value present before the edge. All decoded outputs are mutually aligned.
  - active = (h < H_ACTIVE) && (v < V_ACTIVE).
  - display_next_pixel = active. It pulses on every clock of the active window.
  - display_next_line = (h == HT-1), on every line including blanking lines.
  - display_next_frame = (h == HT-1) && (v == VT-1). It always coincides with a display_next_line pulse.
  - hsync = SYNC_POL when H_ACTIVE+H_FRONT <= h < H_ACTIVE+H_FRONT+H_SYNC, else ~SYNC_POL.
  - vsync = SYNC_POL when V_ACTIVE+V_FRONT <= v < V_ACTIVE+V_FRONT+V_SYNC, else ~SYNC_POL. The full-line span of v is used, so vsync edges align with the line start.
- Field:
  - On the same edge that asserts display_next_frame: if interlace=1, display_current_field toggles; if interlace=0, it is forced to 0.
  - Changing interlace mid-frame takes effect only at the next frame boundary.
- First enabled edge after reset or after disable: counters go 0 -> 1 and the decode samples (0,0). On that edge active=1 and display_next_pixel=1.
- No other handshakes; outputs are pure free-running strobes. The consumer must sample them on the same clk.

Test Plan:
- Reset and enable: hold rst=0 with enable=1, then release rst; after the first edge -> active=1, display_next_pixel=1; hsync=1 and vsync=1 throughout reset.
- Line timing: run 2 lines -> display_next_pixel high for exactly 640 consecutive clocks per line; display_next_line exactly one pulse every 800 clocks; hsync low for exactly 96 clocks, starting 656 clocks after the active start.
- Frame timing: run 2 frames -> display_next_frame every 420000 clocks, coincident with display_next_line; vsync low for 1600 clocks beginning at line 490; 480 lines carry active pixels per frame.
- Interlace: interlace=1 for 3 frames -> display_current_field goes 0,1,0,1 at each display_next_frame; set interlace=0 mid-frame -> field is unchanged until the next frame boundary, then 0.
- Mid-frame disable: drop enable at h_count=300, v_count=200 for 5 clocks -> h_count=v_count=0, all strobes 0, syncs deasserted; re-enable -> next_pixel resumes on the first edge, with no stray next_frame pulse.
- Async reset mid-line: assert rst between edges at h=700, v=491 (hsync and vsync both asserted) -> all outputs reach reset values immediately, without waiting for clk.
